// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and raster FSM state shared by the timing generator and pixel source
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam bit VGA_SYNC_POL = 1'b0;
  localparam int VGA_LOCK_STABLE = 16;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/vga_sync_2ff.sv
// vga_sync_2ff: two-flop synchroniser (clk, async active-high rst clears to 0, d_i async in, q_o synced out)
module vga_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: qualifies PLL locked then drives VGA raster (refclk/rst/locked in; hsync, vsync, de, pix_x, pix_y, frame_start, running out)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL,
  parameter int LOCK_STABLE = VGA_LOCK_STABLE,
  parameter int XW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int YW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_start,
  output logic          running
);
  localparam int SW = $clog2(LOCK_STABLE) + 1;
  localparam logic [XW-1:0] H_LAST = XW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [XW-1:0] H_DE = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_S0 = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_S1 = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [YW-1:0] V_DE = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_S0 = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_S1 = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE - 1);

  logic lk_s, run;
  state_e state_q, state_d;
  logic [XW-1:0] h_cnt_q, h_cnt_d, pix_x_q, pix_x_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d, pix_y_q, pix_y_d;
  logic [SW-1:0] stab_q, stab_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;

  vga_sync_2ff u_sync (
    .clk(refclk),
    .rst(rst),
    .d_i(locked),
    .q_o(lk_s)
  );

  always_comb begin
    state_d = state_q;
    stab_d = '0;
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (state_q == IDLE) begin
      stab_d = lk_s ? stab_q + 1'b1 : '0;
      if (lk_s && stab_q == S_LAST) begin
        state_d = RUN;
        stab_d = '0;
      end
    end else if (!lk_s) begin
      state_d = IDLE;
    end else begin
      h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    run = state_q == RUN;
    de_d = run && h_cnt_q < H_DE && v_cnt_q < V_DE;
    pix_x_d = de_d ? h_cnt_q : '0;
    pix_y_d = de_d ? v_cnt_q : '0;
    hsync_d = (run && h_cnt_q >= H_S0 && h_cnt_q < H_S1) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (run && v_cnt_q >= V_S0 && v_cnt_q < V_S1) ? SYNC_POL : ~SYNC_POL;
    fs_d = run && h_cnt_q == '0 && v_cnt_q == '0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stab_q <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q <= stab_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q <= de_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      fs_q <= fs_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de = de_q;
  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
  assign frame_start = fs_q;
  assign running = state_q == RUN;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized lock stimulus against a time-based raster model, scoreboard-checked on three builds
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst, locked;
  logic hs_a, vs_a, de_a, fs_a, run_a;
  logic [9:0] x_a, y_a;
  logic hs_b, vs_b, de_b, fs_b, run_b;
  logic [4:0] x_b, y_b;
  logic hs_c, vs_c, de_c, fs_c, run_c;
  logic [4:0] x_c, y_c;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .refclk(clk), .rst(rst), .locked(locked), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a), .running(run_a)
  );
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .refclk(clk), .rst(rst), .locked(locked), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b), .running(run_b)
  );
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) u_c (
    .refclk(clk), .rst(rst), .locked(locked), .hsync(hs_c), .vsync(vs_c), .de(de_c),
    .pix_x(x_c), .pix_y(y_c), .frame_start(fs_c), .running(run_c)
  );

  typedef struct {bit hs, vs, de, fs; int x, y;} out_t;
  typedef struct {out_t a, b, c; bit run;} exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  bit m_run;
  int m_t, m_stab;
  bit m_dly[$];

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Expected outputs after an edge, from the time elapsed since the raster started.
  function automatic out_t ref_out(input int t, input bit run, input int ha, hf, hs, hb,
                                   input int va, vf, vs, vb, input bit pol);
    out_t o;
    int h, v;
    o.hs = !pol; o.vs = !pol; o.de = 0; o.fs = 0; o.x = 0; o.y = 0;
    if (run) begin
      h = t % (ha + hf + hs + hb);
      v = (t / (ha + hf + hs + hb)) % (va + vf + vs + vb);
      o.de = h < ha && v < va;
      o.x = o.de ? h : 0;
      o.y = o.de ? v : 0;
      o.hs = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
      o.vs = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
      o.fs = h == 0 && v == 0;
    end
    return o;
  endfunction

  task automatic cmp_out(input string p, input logic hs, vs, de, fs, input int x, y, input out_t o);
    cmp({p, ".hsync"}, int'(hs), int'(o.hs));
    cmp({p, ".vsync"}, int'(vs), int'(o.vs));
    cmp({p, ".de"}, int'(de), int'(o.de));
    cmp({p, ".frame_start"}, int'(fs), int'(o.fs));
    cmp({p, ".pix_x"}, x, o.x);
    cmp({p, ".pix_y"}, y, o.y);
  endtask

  task automatic model_reset();
    m_run = 0;
    m_t = 0;
    m_stab = 0;
    m_dly = {1'b0, 1'b0};
  endtask

  // Called at a negedge: drive locked, predict the coming edge, advance to next negedge.
  task automatic step(input bit l);
    exp_t e;
    bit lks;
    locked = l;
    lks = m_dly.pop_front();
    m_dly.push_back(l);
    e.a = ref_out(m_t, m_run, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    e.b = ref_out(m_t, m_run, 16, 4, 6, 6, 12, 2, 2, 3, 1'b0);
    e.c = ref_out(m_t, m_run, 16, 4, 6, 6, 12, 2, 2, 3, 1'b1);
    if (m_run) begin
      if (!lks) begin
        m_run = 0;
        m_stab = 0;
      end else m_t++;
    end else if (lks) begin
      if (m_stab == 15) begin
        m_run = 1;
        m_t = 0;
        m_stab = 0;
      end else m_stab++;
    end else m_stab = 0;
    e.run = m_run;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_reset();
    cmp_out("rst.A", hs_a, vs_a, de_a, fs_a, int'(x_a), int'(y_a), ref_out(0, 0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    cmp_out("rst.B", hs_b, vs_b, de_b, fs_b, int'(x_b), int'(y_b), ref_out(0, 0, 16, 4, 6, 6, 12, 2, 2, 3, 1'b0));
    cmp_out("rst.C", hs_c, vs_c, de_c, fs_c, int'(x_c), int'(y_c), ref_out(0, 0, 16, 4, 6, 6, 12, 2, 2, 3, 1'b1));
    cmp("rst.running", int'({run_a, run_b, run_c}), 0);
  endtask

  task automatic wait_pos(input int ln, input int col);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (m_run && (m_t / 32) % 19 == ln && m_t % 32 == col) break;
      step(1);
    end
    cmp("wait_pos_timeout", int'(i < 2000), 1);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp_out("A", hs_a, vs_a, de_a, fs_a, int'(x_a), int'(y_a), e.a);
      cmp_out("B", hs_b, vs_b, de_b, fs_b, int'(x_b), int'(y_b), e.b);
      cmp_out("C", hs_c, vs_c, de_c, fs_c, int'(x_c), int'(y_c), e.c);
      cmp("A.running", int'(run_a), int'(e.run));
      cmp("B.running", int'(run_b), int'(e.run));
      cmp("C.running", int'(run_c), int'(e.run));
    end
  end

  initial begin
    bit l;
    int n;
    rst = 1'b1;
    locked = 1'b0;
    model_reset();
    #3 chk_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (9000) step(1);
    wait_pos(5, 3);
    repeat (3) step(0);
    repeat (1500) step(1);
    repeat (30) step(0);
    repeat (10) step(1);
    step(0);
    repeat (200) step(1);
    repeat (40) begin
      l = ($urandom % 4) != 0;
      n = $urandom_range(1, 60);
      repeat (n) step(l);
    end
    repeat (1000) step(1);
    wait_pos(10, 5);
    #3 rst = 1'b1;
    #1 chk_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (100) step(1);
    cmp("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
